// File: rtl/mq_byte_packer_if.sv
// mq_byte_packer_if: byte-in / word-out bundle for the MQ byte packer.
// The master side drives coded bytes, flush and word_ready; the slave side
// (the packer) returns packed words plus segment status.
interface mq_byte_packer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  word_bytes;
  logic        word_last;
  logic [15:0] byte_count;
  logic        busy;
  logic        overflow;
  logic        marker_err;

  modport master (
    output byte_in, byte_valid, flush, word_ready,
    input  word_out, word_valid, word_bytes, word_last,
    input  byte_count, busy, overflow, marker_err
  );

  modport slave (
    input  byte_in, byte_valid, flush, word_ready,
    output word_out, word_valid, word_bytes, word_last,
    output byte_count, busy, overflow, marker_err
  );
endinterface

// File: rtl/mq_byte_packer.sv
// mq_byte_packer: packs MQ coder bytes big-endian into 32-bit words, queues
// them in a small FIFO and terminates each code-block segment on flush.
// The input is never stalled; lost bytes/words raise a sticky overflow flag.
// Optional feature: define MQ_PACK_MARKER_CHECK_EN to build the illegal
// marker detector (a byte > 8'h8F directly after 8'hFF sets marker_err).
module mq_byte_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  mq_byte_packer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 37;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [23:0]   acc_q, acc_d;
  logic [1:0]    fill_q, fill_d;
  logic [15:0]   byteCount_q, byteCount_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic          empty, full, pop, lastPop, accept, pushReq, pushOk;
  logic          fullWord;
  logic [31:0]   wordData, pushData;
  logic [2:0]    pushBytes;
  logic          pushLast;
  logic [PW-1:0] occupancy;
  logic [EW-1:0] head;

  assign empty     = (wrPtr_q == rdPtr_q);
  assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign occupancy = wrPtr_q - rdPtr_q;
  assign pop       = !empty && bus.word_ready;
  assign lastPop   = pop && (occupancy == PW'(1));
  assign pushOk    = pushReq && (!full || pop);

  // Byte assembly, flush termination, segment state and overflow detection
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    byteCount_d = byteCount_q;
    overflow_d  = overflow_q;
    pushReq     = 1'b0;
    pushData    = 32'h0;
    pushBytes   = 3'd0;
    pushLast    = 1'b0;
    fullWord    = 1'b0;
    wordData    = 32'h0;
    accept      = bus.byte_valid && (state_q != DRAIN);

    if (bus.byte_valid && (state_q == DRAIN)) overflow_d = 1'b1;

    if (accept) begin
      if (byteCount_q != 16'hFFFF) byteCount_d = byteCount_q + 16'd1;
      if (state_q == IDLE) state_d = ACTIVE;
      case (fill_q)
        2'd0: begin acc_d[23:16] = bus.byte_in; fill_d = 2'd1; end
        2'd1: begin acc_d[15:8]  = bus.byte_in; fill_d = 2'd2; end
        2'd2: begin acc_d[7:0]   = bus.byte_in; fill_d = 2'd3; end
        default: begin
          fullWord = 1'b1;
          wordData = {acc_q, bus.byte_in};
          acc_d    = 24'h0;
          fill_d   = 2'd0;
        end
      endcase
    end

    if (bus.flush && ((state_q == ACTIVE) || ((state_q == IDLE) && bus.byte_valid))) begin
      pushReq  = 1'b1;
      pushLast = 1'b1;
      state_d  = DRAIN;
      if (fullWord) begin
        pushData  = wordData;
        pushBytes = 3'd4;
      end else if (fill_d != 2'd0) begin
        pushData  = {acc_d, 8'h00};
        pushBytes = {1'b0, fill_d};
      end
      acc_d  = 24'h0;
      fill_d = 2'd0;
    end else if (fullWord) begin
      pushReq   = 1'b1;
      pushData  = wordData;
      pushBytes = 3'd4;
    end

    if (pushReq && full && !pop) overflow_d = 1'b1;

    if ((state_q == DRAIN) && (empty || lastPop)) begin
      state_d     = IDLE;
      byteCount_d = 16'h0;
    end
  end

  // Control registers and FIFO pointers; reset drops everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 24'h0;
      fill_q      <= 2'd0;
      byteCount_q <= 16'h0;
      overflow_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      byteCount_q <= byteCount_d;
      overflow_q  <= overflow_d;
      wrPtr_q     <= wrPtr_q + PW'(pushOk);
      rdPtr_q     <= rdPtr_q + PW'(pop);
    end
  end

  // FIFO storage; top bit tags an entry as written so stale slots never leak out
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= {1'b1, pushLast, pushBytes, pushData};
  end

  assign head           = mem_q[rdPtr_q[AW-1:0]];
  assign bus.word_valid = !empty;
  assign bus.word_out   = (!empty && head[36]) ? head[31:0]  : 32'h0;
  assign bus.word_bytes = (!empty && head[36]) ? head[34:32] : 3'd0;
  assign bus.word_last  = !empty && head[36] && head[35];
  assign bus.byte_count = byteCount_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overflow   = overflow_q;

`ifdef MQ_PACK_MARKER_CHECK_EN
  logic [7:0] prevByte_q;
  logic       markerErr_q;

  // Track the last accepted byte across word boundaries and flag FF followed by > 8F
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevByte_q  <= 8'h0;
      markerErr_q <= 1'b0;
    end else if ((state_q == DRAIN) && (state_d == IDLE)) begin
      prevByte_q <= 8'h0;
    end else if (accept) begin
      if ((prevByte_q == 8'hFF) && (bus.byte_in > 8'h8F)) markerErr_q <= 1'b1;
      prevByte_q <= bus.byte_in;
    end
  end

  assign bus.marker_err = markerErr_q;
`else
  assign bus.marker_err = 1'b0;
`endif

endmodule

// File: doc/mq_byte_packer.md
# mq_byte_packer

Downstream stage of the MQ arithmetic coder in the JPEG2000 Tier-1 path. It takes the coder's byte stream (`byte_out` / `output_valid`), packs bytes big-endian into 32-bit words and buffers them in a small FIFO. It presents the words on a valid/ready interface to the codestream writer and terminates each code-block segment on `flush`. The coder cannot stall, so this block never back-pressures its input; it reports loss with a sticky flag instead.

## Interface
- `FIFO_DEPTH`, 8: word FIFO depth; must be a power of 2, minimum 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `byte_in`  in  8  coded byte from the MQ coder.
- `byte_valid`  in  1  `byte_in` valid this cycle; at most one byte per cycle.
- `flush`  in  1  single-cycle pulse marking end of the segment.
- `word_out`  out  32  packed word; the first byte occupies [31:24].
- `word_valid`  out  1  `word_out` holds a FIFO head entry.
- `word_ready`  in  1  consumer accepts the word when it is high together with `word_valid`.
- `word_bytes`  out  3  number of valid bytes in `word_out`, 0..4.
- `word_last`  out  1  the word is the final word of the segment.
- `byte_count`  out  16  bytes accepted in the current segment; saturates at 16'hFFFF.
- `busy`  out  1  state is not IDLE.
- `overflow`  out  1  sticky; a word or byte was dropped.
- `marker_err`  out  1  sticky; illegal marker detected (see Configuration).

## Operation
- States:
  - IDLE: no bytes held.
  - ACTIVE: accumulating bytes.
  - DRAIN: flush accepted, waiting for the FIFO to empty.
- Transitions:
  - IDLE→ACTIVE on `byte_valid`.
  - ACTIVE→DRAIN on `flush`.
  - DRAIN→IDLE when the FIFO is empty and no pop is pending.
  - `byte_count` clears on DRAIN→IDLE.
- Assembly register: 24-bit data plus a 2-bit `fill` count, 0..3.
  - An accepted byte goes to lane `3-fill`.
  - When a byte arrives with `fill`==3, the full word (3 held bytes plus the incoming byte) is pushed the same cycle with `word_bytes`=4 and `last`=0, and `fill` becomes 0.
- Flush in ACTIVE:
  - Any `byte_valid` in the same cycle is processed first.
  - If the resulting `fill`>0, push a partial word: unused low lanes 0x00, `word_bytes`=`fill`, `last`=1.
  - If the byte completed a word in that same cycle, that word is pushed with `last`=1.
  - Otherwise push a terminator word: `word_out`=0, `word_bytes`=0, `last`=1.
- Flush in IDLE with `byte_valid` high: handled as IDLE→ACTIVE followed by the ACTIVE flush, and the state goes to DRAIN.
- Flush in IDLE without `byte_valid`: ignored.
- Flush in DRAIN: ignored.
- `byte_valid` in DRAIN: the byte is discarded and `overflow` is set.
- Push while the FIFO is full: the word is dropped and `overflow` is set. The exception is a same-cycle pop, in which case the push succeeds.
- FIFO entry is 37 bits: data 32, `word_bytes` 3, `last` 1, plus spare.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.

## Timing
- Reset values:
  - `word_out`=0, `word_valid`=0, `word_bytes`=0, `word_last`=0.
  - `byte_count`=0, `busy`=0, `overflow`=0, `marker_err`=0.
  - State is IDLE, `fill`=0, FIFO is empty.
- Latency: a word pushed in cycle N shows `word_valid`=1 in cycle N+1 (outputs are registered).
- Pop at edge N when `word_valid`&&`word_ready`; the next entry appears in N+1 with no bubble.
- `word_out`, `word_bytes` and `word_last` stay stable while `word_valid`=1 and `word_ready`=0.
- `byte_count` updates in the cycle after an accepted byte; discarded bytes are not counted.
- `busy` goes high the cycle after the first byte and low the cycle after the final pop of DRAIN.
- An `rst_n` assertion mid-segment discards all held bytes and FIFO contents immediately.

## Configuration
- `MQ_PACK_MARKER_CHECK_EN` defined:
  - A previous-byte register tracks the last accepted byte across word boundaries.
  - An accepted byte >8'h8F immediately after an 8'hFF sets `marker_err`, sticky until reset.
  - The previous-byte register clears on DRAIN→IDLE.
- `MQ_PACK_MARKER_CHECK_EN` undefined: the previous-byte register is not built and `marker_err` is tied to 0.

## Test plan
- Bytes 11,22,33,44,55 on consecutive cycles, then flush, with `word_ready`=1 → word 11223344/bytes 4/last 0, then 55000000/bytes 3... correction: word 11223344 (`word_bytes`=4, `word_last`=0), then 55000000 (`word_bytes`=1, `word_last`=1); `byte_count`=5 until IDLE.
- 8 bytes followed by flush in the cycle after the 8th byte → two full words, then terminator 00000000 (`word_bytes`=0, `word_last`=1).
- 4th byte and flush in the same cycle → a single word with `word_bytes`=4 and `word_last`=1, and no terminator.
- `word_ready`=0 while 40 bytes arrive with FIFO_DEPTH=8 → 8 words held, 9th and 10th words dropped, `overflow`=1; after `word_ready`=1, exactly 8 words drain in order.
- Bytes FF,90 with the macro defined → `marker_err`=1; bytes FF,7F → `marker_err` stays 0; with the macro undefined, `marker_err` is always 0.
- Assert `rst_n` with 3 bytes held and 2 words queued → all outputs at reset values next cycle and `word_valid`=0.
